boot_select: RTL and testbench
==============================

Name: boot_select

Overview:
Parametrised coldboot image selector for the iCE40 multi-image flash layout. It synchronises and debounces the user button and opens a configurable boot window. Button state and press duration pick one of three warmboot images: application, DFU bootloader, or alternate. It then drives the warmboot select/boot request, and sits in the first-stage header image.

Parameters:
DELAY_CYCLES, 255, boot window length in pin_clk cycles after reset release (0 allowed)
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to change debounced state (>=1)
HOLD_CYCLES, 4096, press duration at/after which the alternate image is chosen (>=1)
APP_IMAGE, 2, image slot when button released at window end
DFU_IMAGE, 1, image slot for short press (released before HOLD_CYCLES)
ALT_IMAGE, 3, image slot for long press

Ports:
pin_clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
pin_btn_n  in  1  raw button, active-low, asynchronous to pin_clk
boot_inhibit  in  1  holds the block in ARM; blocks the boot request
btn_pressed  out  1  debounced button state, 1 = pressed
boot_s  out  2  selected image slot {S1,S0}
sel_valid  out  1  boot_s is final
boot_req  out  1  warmboot trigger, sticky

Behaviour:
- Reset values: btn_pressed=0, boot_s=2'b00, sel_valid=0, boot_req=0, state=WINDOW, counter=DELAY_CYCLES, sync flops=1 (released), debounce count=0.
- Sync: 2-flop synchroniser on pin_btn_n, inverted to active-high.
- Debounce: btn_pressed toggles only after the synchronised value differs from btn_pressed for DEBOUNCE_CYCLES consecutive cycles. Any matching sample clears the count. Input-to-btn_pressed latency = 2 + DEBOUNCE_CYCLES cycles.
- Counter width = $clog2(max(DELAY_CYCLES,HOLD_CYCLES)+1); decrement saturates at 0.
- FSM:
  WINDOW: decrement each cycle. When counter==0, sample btn_pressed. If 0: boot_s<=APP_IMAGE, go ARM. If 1: counter<=HOLD_CYCLES-1, go HOLD. With DELAY_CYCLES=0, evaluation occurs on the first clock after reset release.
  HOLD: if !btn_pressed: boot_s<=DFU_IMAGE, go ARM. Else if counter==0: boot_s<=ALT_IMAGE, go ARM. Else decrement. Release and counter==0 in the same cycle -> DFU (release wins).
  ARM: sel_valid=1. If !boot_inhibit, go BOOT next cycle; otherwise stay.
  BOOT: boot_req=1, sel_valid=1, boot_s frozen; terminal until reset.
- boot_s is never changed after leaving WINDOW/HOLD. boot_req rises at least one cycle after boot_s is stable (setup for the warmboot primitive).
- Button activity after ARM is ignored by the FSM; btn_pressed continues to track.
- rst_n assertion in any state returns all outputs to reset values asynchronously. Deassertion restarts the full window.
- Image parameters are truncated to 2 bits.

Optional Feature:
BOOT_SELECT_WARMBOOT_EN
- Defined: the block instantiates SB_WARMBOOT internally with S1=boot_s[1], S0=boot_s[0], BOOT=boot_req. Ports are unchanged and still driven.
- Undefined: no primitive; the parent instantiates SB_WARMBOOT from boot_s/boot_req (simulation-friendly).

Decomposition:
- Shared include boot_select_defs.vh holds the FSM state encodings (WINDOW=0, HOLD=1, ARM=2, BOOT=3) and the image slot constants IMG_BOOT=0, IMG_DFU=1, IMG_APP=2, IMG_ALT=3 used by bootloader and application builds.
- One sub-module: btn_debounce (synchroniser + debounce counter, parameter DEBOUNCE_CYCLES, ports pin_clk, rst_n, raw_n, pressed). It is reusable for other front-panel buttons.

Test Plan:
- DELAY=8, DEBOUNCE=4, button released throughout -> boot_s=2, sel_valid rises cycle 9 after reset release, boot_req rises cycle 10, both stay high 100 cycles.
- Button held from reset, released 10 cycles into HOLD (HOLD=32) -> boot_s=1, boot_req one cycle after sel_valid.
- Button held 200 cycles, HOLD=32 -> boot_s=3 selected exactly 32 HOLD cycles after window end. Later release leaves boot_s=3.
- Button chatter (1-cycle glitches every 3 cycles, DEBOUNCE=4) at window end -> btn_pressed stays 0, boot_s=2.
- boot_inhibit=1 during ARM for 50 cycles -> sel_valid=1, boot_req=0 throughout. Release inhibit -> boot_req=1 the next cycle.
- rst_n pulsed low while in HOLD -> all outputs 0 immediately, counter reloads 8, sequence restarts and re-evaluates the button.

Source files
------------

// File: rtl/boot_select_pkg.sv
// Shared definitions for the coldboot image selector: FSM state encodings and image slots.
// Bootloader and application builds import these so slot numbers agree across images.
package boot_select_pkg;

    typedef enum logic [1:0] {
        ST_WINDOW = 2'd0,
        ST_HOLD   = 2'd1,
        ST_ARM    = 2'd2,
        ST_BOOT   = 2'd3
    } state_e;

    localparam logic [1:0] IMG_BOOT = 2'd0;
    localparam logic [1:0] IMG_DFU  = 2'd1;
    localparam logic [1:0] IMG_APP  = 2'd2;
    localparam logic [1:0] IMG_ALT  = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Front-panel button synchroniser plus debouncer; pressed is active-high.
// Latency 2 + DEBOUNCE_CYCLES cycles from raw_n edge to pressed; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic pin_clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic pressed
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          pressed_q, pressed_d;
    logic [DW-1:0] cnt_q, cnt_d;

    // Count only consecutive disagreeing samples; any agreeing sample restarts the run.
    always_comb begin
        pressed_d = pressed_q;
        cnt_d     = '0;
        if ((~sync2_q) != pressed_q) begin
            if (cnt_q == LAST) begin
                pressed_d = ~pressed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pin_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= raw_n;
            sync2_q   <= sync1_q;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pressed = pressed_q;

endmodule

// File: rtl/boot_select.sv
// Coldboot image selector: button state/press length at end of boot window picks the warmboot slot.
// Optional BOOT_SELECT_WARMBOOT_EN instantiates SB_WARMBOOT internally; boot_req is sticky until reset.
module boot_select
    import boot_select_pkg::*;
#(
    parameter int DELAY_CYCLES    = 255,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 4096,
    parameter int APP_IMAGE       = 2,
    parameter int DFU_IMAGE       = 1,
    parameter int ALT_IMAGE       = 3
) (
    input  logic       pin_clk,
    input  logic       rst_n,
    input  logic       pin_btn_n,
    input  logic       boot_inhibit,
    output logic       btn_pressed,
    output logic [1:0] boot_s,
    output logic       sel_valid,
    output logic       boot_req
);

    localparam int CW = $clog2(max_int(DELAY_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [CW-1:0] DELAY_LOAD = CW'(DELAY_CYCLES);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [1:0]    APP_S = APP_IMAGE[1:0];
    localparam logic [1:0]    DFU_S = DFU_IMAGE[1:0];
    localparam logic [1:0]    ALT_S = ALT_IMAGE[1:0];

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      boot_s_q, boot_s_d;
    logic            sel_valid_q, boot_req_q;
    logic            pressed;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .pin_clk (pin_clk),
        .rst_n   (rst_n),
        .raw_n   (pin_btn_n),
        .pressed (pressed)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        boot_s_d = boot_s_q;
        unique case (state_q)
            ST_WINDOW: begin
                if (cnt_q == '0) begin
                    if (!pressed) begin
                        boot_s_d = APP_S;
                        state_d  = ST_ARM;
                    end else begin
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Release beats expiry when both land on the same cycle.
            ST_HOLD: begin
                if (!pressed) begin
                    boot_s_d = DFU_S;
                    state_d  = ST_ARM;
                end else if (cnt_q == '0) begin
                    boot_s_d = ALT_S;
                    state_d  = ST_ARM;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ARM: begin
                if (!boot_inhibit) begin
                    state_d = ST_BOOT;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Outputs registered from next state so boot_req always trails a settled boot_s.
    always_ff @(posedge pin_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WINDOW;
            cnt_q       <= DELAY_LOAD;
            boot_s_q    <= 2'b00;
            sel_valid_q <= 1'b0;
            boot_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            boot_s_q    <= boot_s_d;
            sel_valid_q <= (state_d == ST_ARM) || (state_d == ST_BOOT);
            boot_req_q  <= (state_d == ST_BOOT);
        end
    end

    assign btn_pressed = pressed;
    assign boot_s      = boot_s_q;
    assign sel_valid   = sel_valid_q;
    assign boot_req    = boot_req_q;

`ifdef BOOT_SELECT_WARMBOOT_EN
    SB_WARMBOOT u_warmboot (
        .BOOT (boot_req_q),
        .S1   (boot_s_q[1]),
        .S0   (boot_s_q[0])
    );
`else
    // Parent instantiates SB_WARMBOOT from boot_s/boot_req.
`endif

endmodule

// File: tb/tb_boot_select.sv
// Randomised and directed bench for boot_select against an edge-count reference model.
module tb_boot_select;

    localparam int DELAY = 8;
    localparam int DEB   = 4;
    localparam int HOLD  = 32;

    logic       pin_clk      = 1'b0;
    logic       rst_n        = 1'b0;
    logic       pin_btn_n    = 1'b1;
    logic       boot_inhibit = 1'b0;
    logic       btn_pressed;
    logic [1:0] boot_s;
    logic       sel_valid;
    logic       boot_req;

    int vectors     = 0;
    int miscompares = 0;

    always #5 pin_clk = ~pin_clk;

    boot_select #(
        .DELAY_CYCLES    (DELAY),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .APP_IMAGE       (2),
        .DFU_IMAGE       (1),
        .ALT_IMAGE       (3)
    ) dut (
        .pin_clk      (pin_clk),
        .rst_n        (rst_n),
        .pin_btn_n    (pin_btn_n),
        .boot_inhibit (boot_inhibit),
        .btn_pressed  (btn_pressed),
        .boot_s       (boot_s),
        .sel_valid    (sel_valid),
        .boot_req     (boot_req)
    );

    // Reference model: t counts clock edges since reset release.
    int         t;
    bit         m_pressed, pre, s, all_diff;
    bit         rq[$];
    bit         hist[$];
    bit         decided, holding, booted;
    int         hold_start, arm_t;
    logic [1:0] m_img;

    always @(posedge pin_clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; m_pressed = 0; rq = {1'b1, 1'b1}; hist = {};
            decided = 0; holding = 0; booted = 0; hold_start = 0; arm_t = 0; m_img = 2'd0;
        end else begin
            pre = m_pressed;
            t++;
            if (!decided) begin
                if (!holding) begin
                    if (t == DELAY + 1) begin
                        if (!pre) begin m_img = 2'd2; decided = 1; arm_t = t; end
                        else begin holding = 1; hold_start = t; end
                    end
                end else if (!pre) begin
                    m_img = 2'd1; decided = 1; arm_t = t;
                end else if (t == hold_start + HOLD) begin
                    m_img = 2'd3; decided = 1; arm_t = t;
                end
            end else if (!booted && t > arm_t && !boot_inhibit) begin
                booted = 1;
            end
            // Debounced state flips once the last DEB synchronised samples all disagree with it.
            s = !rq[0];
            void'(rq.pop_front());
            rq.push_back(pin_btn_n);
            hist.push_back(s);
            if (hist.size() > DEB) void'(hist.pop_front());
            if (hist.size() == DEB) begin
                all_diff = 1;
                foreach (hist[i]) if (hist[i] == pre) all_diff = 0;
                if (all_diff) m_pressed = !pre;
            end
        end
    end

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge pin_clk) begin
        chk("btn_pressed", {1'b0, btn_pressed}, {1'b0, m_pressed});
        chk("boot_s",      boot_s,              m_img);
        chk("sel_valid",   {1'b0, sel_valid},   {1'b0, decided});
        chk("boot_req",    {1'b0, boot_req},    {1'b0, booted});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pin_clk);
        #2;
    endtask

    task automatic reset_seq(input logic btn_n, input logic inh);
        rst_n = 1'b0;
        pin_btn_n = btn_n;
        boot_inhibit = inh;
        tick(2);
        rst_n = 1'b1;
    endtask

    int  run_len;
    bit  saw_press;

    initial begin
        tick(1);
        // Released throughout: APP, sel_valid at edge 9, boot_req at edge 10.
        reset_seq(1'b1, 1'b0);
        tick(DELAY);
        chk("pin_sel_before_window", {1'b0, sel_valid}, 2'd0);
        tick(1);
        chk("pin_sel_at_window", {1'b0, sel_valid}, 2'd1);
        chk("pin_req_at_window", {1'b0, boot_req}, 2'd0);
        tick(1);
        chk("pin_req_next", {1'b0, boot_req}, 2'd1);
        chk("pin_app_slot", boot_s, 2'd2);
        tick(100);
        chk("pin_req_sticky", {1'b0, boot_req}, 2'd1);

        // Short press: released inside HOLD -> DFU.
        reset_seq(1'b0, 1'b0);
        tick(DELAY + 1 + 10);
        pin_btn_n = 1'b1;
        tick(40);
        chk("pin_dfu_slot", boot_s, 2'd1);

        // Long press: ALT exactly HOLD cycles after window end (edge 41).
        reset_seq(1'b0, 1'b0);
        tick(DELAY + HOLD);
        chk("pin_alt_not_yet", {1'b0, sel_valid}, 2'd0);
        tick(1);
        chk("pin_alt_sel", {1'b0, sel_valid}, 2'd1);
        chk("pin_alt_slot", boot_s, 2'd3);
        tick(159);
        pin_btn_n = 1'b1;
        tick(30);
        chk("pin_alt_after_release", boot_s, 2'd3);
        chk("pin_btn_released", {1'b0, btn_pressed}, 2'd0);

        // Chatter: one-cycle glitch every third cycle never debounces.
        reset_seq(1'b1, 1'b0);
        saw_press = 0;
        for (int i = 0; i < 60; i++) begin
            pin_btn_n = (i % 3 == 0) ? 1'b0 : 1'b1;
            tick(1);
            if (btn_pressed) saw_press = 1;
        end
        pin_btn_n = 1'b1;
        chk("pin_chatter_pressed", {1'b0, saw_press}, 2'd0);
        chk("pin_chatter_slot", boot_s, 2'd2);

        // Inhibit holds ARM; release boots on the next edge.
        reset_seq(1'b1, 1'b1);
        tick(60);
        chk("pin_inh_sel", {1'b0, sel_valid}, 2'd1);
        chk("pin_inh_req", {1'b0, boot_req}, 2'd0);
        boot_inhibit = 1'b0;
        tick(1);
        chk("pin_inh_release_req", {1'b0, boot_req}, 2'd1);

        // Reset while in HOLD clears outputs at once and re-evaluates.
        reset_seq(1'b0, 1'b0);
        tick(20);
        rst_n = 1'b0;
        #1;
        chk("pin_arst_pressed", {1'b0, btn_pressed}, 2'd0);
        chk("pin_arst_sel", {1'b0, sel_valid}, 2'd0);
        chk("pin_arst_slot", boot_s, 2'd0);
        pin_btn_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(DELAY + 1);
        chk("pin_restart_sel", {1'b0, sel_valid}, 2'd1);
        chk("pin_restart_slot", boot_s, 2'd2);
        tick(5);

        // Random button runs and inhibit toggles.
        for (int r = 0; r < 8; r++) begin
            reset_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_len = 0;
            for (int c = 0; c < 300; c++) begin
                if (run_len == 0) begin
                    pin_btn_n = ~pin_btn_n;
                    run_len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 60);
                end
                run_len--;
                if ($urandom_range(0, 15) == 0) boot_inhibit = ~boot_inhibit;
                tick(1);
            end
            boot_inhibit = 1'b0;
            tick(3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
